// File: rtl/pe_pkg.sv
// pe_pkg: shared channel count and debounce defaults for the priority-encoder front end
package pe_pkg;
  localparam int PE_WIDTH = 8;
  localparam int DEB_STABLE_CNT_DEFAULT = 500000;
  localparam int DEB_CNT_W_DEFAULT = 19;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one-channel synchronizer and debouncer, rise pulse built under DEBOUNCE_PULSE_EN
module debounce_bit
  import pe_pkg::*;
#(
  parameter int STABLE_CNT = DEB_STABLE_CNT_DEFAULT,
  parameter int CNT_W = DEB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic busy
);
  logic s1, s2, done;
  logic [CNT_W-1:0] cnt;
  assign done = s2 != out && cnt == CNT_W'(STABLE_CNT - 1);
  assign busy = |cnt;
  // synchronize, count consecutive mismatches, and follow the input once the window is full
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      out <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      out <= done ? s2 : out;
      cnt <= (s2 == out || done) ? '0 : cnt + CNT_W'(1);
    end
  end
`ifdef DEBOUNCE_PULSE_EN
  // single-cycle pulse on the edge that moves out from 0 to 1
  always_ff @(posedge clk) begin
    rise <= !reset && done && s2;
  end
`else
  assign rise = 1'b0;
`endif
endmodule

// File: rtl/button_debounce8.sv
// button_debounce8: eight independent debounced button channels, rise pulses under DEBOUNCE_PULSE_EN
module button_debounce8
  import pe_pkg::*;
#(
  parameter int STABLE_CNT = DEB_STABLE_CNT_DEFAULT,
  parameter int CNT_W = DEB_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PE_WIDTH-1:0] in,
  output logic [PE_WIDTH-1:0] out,
  output logic [PE_WIDTH-1:0] rise,
  output logic                busy
);
  logic [PE_WIDTH-1:0] bsy;
  assign busy = |bsy;
  for (genvar i = 0; i < PE_WIDTH; i++) begin : g_ch
    debounce_bit #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_bit (
      .clk(clk),
      .reset(reset),
      .in(in[i]),
      .out(out[i]),
      .rise(rise[i]),
      .busy(bsy[i])
    );
  end
endmodule

// File: tb/tb_button_debounce8.sv
// tb_button_debounce8: scoreboard bench for button_debounce8 with STABLE_CNT=4, CNT_W=3
module tb_button_debounce8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in = 8'hFF;
  logic [7:0] out, rise;
  logic busy;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int c;
  logic [7:0] pout = 8'h00;

  typedef struct {
    int cyc;
    logic [7:0] o;
    logic [7:0] r;
  } ev_t;
  ev_t q[$];

  button_debounce8 #(.STABLE_CNT(4), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .out(out),
    .rise(rise),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] rx(logic [7:0] v);
`ifdef DEBOUNCE_PULSE_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic push(int at, logic [7:0] o, logic [7:0] r);
    ev_t e;
    e.cyc = at;
    e.o = o;
    e.r = r;
    q.push_back(e);
  endtask

  task automatic adv(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (out !== pout || rise !== 8'h00) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d out=%h rise=%h", cyc, out, rise);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || out !== e.o || rise !== e.r) begin
          fails++;
          $display("FAIL event got cyc=%0d out=%h rise=%h required cyc=%0d out=%h rise=%h",
                   cyc, out, rise, e.cyc, e.o, e.r);
        end
      end
    end
    pout = out;
  end

  initial begin
    for (int k = 0; k < 6; k++) begin
      adv(1);
      chk("reset_hold", {7'd0, out, busy}, 16'h0000);
      chk("reset_rise", {8'h00, rise}, 16'h0000);
    end
    reset = 1'b0;
    push(cyc + 6, 8'hFF, rx(8'hFF));
    adv(3);
    chk("release_busy", {15'd0, busy}, 16'h0001);
    adv(5);
    chk("release_out", {7'd0, out, busy}, {7'd0, 8'hFF, 1'b0});
    in = 8'h00;
    push(cyc + 6, 8'h00, 8'h00);
    adv(8);
    in = 8'h08;
    push(cyc + 6, 8'h08, rx(8'h08));
    adv(4);
    chk("press_busy", {15'd0, busy}, 16'h0001);
    adv(4);
    chk("press_done", {7'd0, out, busy}, {7'd0, 8'h08, 1'b0});
    in = 8'h09;
    adv(3);
    in = 8'h08;
    adv(1);
    chk("glitch_busy_hi", {15'd0, busy}, 16'h0001);
    adv(5);
    chk("glitch_done", {7'd0, out, busy}, {7'd0, 8'h08, 1'b0});
    for (int k = 0; k < 10; k++) begin
      in = (k % 4 < 2) ? 8'h28 : 8'h08;
      if (k == 8) push(cyc + 6, 8'h28, rx(8'h20));
      adv(1);
    end
    adv(8);
    chk("bounce_out", {8'h00, out}, 16'h0028);
    in = 8'h08;
    push(cyc + 6, 8'h08, 8'h00);
    adv(8);
    in = 8'h80;
    push(cyc + 6, 8'h80, rx(8'h80));
    adv(8);
    chk("swap_out", {7'd0, out, busy}, {7'd0, 8'h80, 1'b0});
    in = 8'h00;
    push(cyc + 6, 8'h00, 8'h00);
    adv(8);
    in = 8'h80;
    adv(3);
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    chk("midreset_clear", {7'd0, out, busy}, 16'h0000);
    push(cyc + 6, 8'h80, rx(8'h80));
    adv(8);
    chk("midreset_out", {7'd0, out, busy}, {7'd0, 8'h80, 1'b0});
    adv(4);
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
